imem_responder: RTL and testbench

//  Memory-side responder for the req/rdy/valid instruction-fetch protocol. It accepts a request

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_if.sv | 16 +
 rtl/imem_stall_lfsr.sv | 20 ++
 rtl/imem_responder.sv | 95 +++++++++
 tb/tb_imem_responder.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
`timescale 1ns/1ps
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam logic [63:0] ERR_DATA  = '0;

    // Fibonacci LFSR, taps 8,6,5,4, shifting towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/imem_if.sv
// req/rdy/valid instruction-fetch bus between the fetcher (master) and memory (slave).
`timescale 1ns/1ps
interface imem_if #(
    parameter int addressSize = 32,
    parameter int dataSize    = 32
);
    logic                   proc_req;
    logic [addressSize-1:0] addr_in;
    logic                   mem_rdy;
    logic                   valid;
    logic [dataSize-1:0]    rdata;
    logic                   err;

    modport master (output proc_req, addr_in, input  mem_rdy, valid, rdata, err);
    modport slave  (input  proc_req, addr_in, output mem_rdy, valid, rdata, err);
endinterface

// File: rtl/imem_stall_lfsr.sv
// Pseudo-random stall source: free-running 8-bit LFSR gated by stall_en.
`timescale 1ns/1ps
module imem_stall_lfsr
    import imem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall_en,
    output logic stall_now
);
    logic [7:0] lfsr;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= lfsr_next(lfsr);
    end

    assign stall_now = stall_en & lfsr[0];
endmodule

// File: rtl/imem_responder.sv
// Memory-side responder: accepts one fetch at a time and returns the word LATENCY cycles later.
`timescale 1ns/1ps
module imem_responder
    import imem_pkg::*;
#(
    parameter int addressSize = 32,
    parameter int dataSize    = 32,
    parameter int memDepth    = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    imem_if.slave                       bus,
    input  logic                        stall_en,
    input  logic                        prog_we,
    input  logic [$clog2(memDepth)-1:0] prog_addr,
    input  logic [dataSize-1:0]         prog_wdata
);
    localparam int         IW       = $clog2(memDepth);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam state_t     ACC_NEXT = (LATENCY == 1) ? RESP : WAIT;

    state_t                 state, state_nx;
    logic [3:0]             cnt, cnt_nx;
    logic [addressSize-1:0] addr_q, rd_addr;
    logic [IW-1:0]          rd_idx;
    logic                   rd_err;
    logic [dataSize-1:0]    rdata_q;
    logic                   err_q;
    logic                   stall_now;
    logic                   accept;
    logic [dataSize-1:0]    mem [memDepth];

    imem_stall_lfsr u_stall (
        .clk       (clk),
        .rst       (rst),
        .stall_en  (stall_en),
        .stall_now (stall_now)
    );

    assign bus.mem_rdy = !stall_now && (state == IDLE || state == RESP);
    assign accept      = bus.proc_req && bus.mem_rdy;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            default: begin
                if (accept) begin
                    state_nx = ACC_NEXT;
                    cnt_nx   = CNT_INIT;
                end else begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // With LATENCY==1 RESP is entered on the accept edge itself, before addr_q holds the address.
    assign rd_addr = (LATENCY == 1) ? bus.addr_in : addr_q;
    assign rd_idx  = rd_addr[IW+1:2];
    assign rd_err  = (rd_addr[1:0] != 2'b00) || ((rd_addr >> (IW + 2)) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) addr_q <= bus.addr_in;
            if (state_nx == RESP) begin
                err_q   <= rd_err;
                rdata_q <= rd_err ? ERR_DATA[dataSize-1:0] : mem[rd_idx];
            end
        end
    end

    // NOTE: the array has no reset, so it maps onto block RAM and survives rst.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_wdata;
    end

    assign bus.valid = (state == RESP);
    assign bus.err   = bus.valid & err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: table-driven reads plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_imem_responder;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    typedef enum {M_IDLE, M_WAIT, M_RESP} mstate_t;

    localparam logic [31:0] W0   = 32'h00500093;
    localparam logic [31:0] W1   = 32'h00A00113;
    localparam logic [31:0] W2   = 32'h00308193;
    localparam logic [31:0] W3   = 32'h40208233;
    localparam logic [31:0] WTOP = 32'hDEADBEEF;
    localparam logic [31:0] WNEW = 32'hCAFEF00D;

    logic       clk;
    logic       rst;
    logic       stall_en;
    logic       prog_we;
    logic [9:0] prog_addr;
    logic [31:0] prog_wdata;
    logic [7:0] lfsr_m;

    int checks = 0;
    int errors = 0;

    imem_if #(.addressSize(32), .dataSize(32)) bus ();

    imem_responder #(
        .addressSize (32),
        .dataSize    (32),
        .memDepth    (1024),
        .LATENCY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .stall_en   (stall_en),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Golden stall LFSR: x^8+x^6+x^5+x^4, seed A5, one step per clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 8'hA5;
        else      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic prog(input logic [9:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        prog_we    = 1'b1;
        prog_addr  = idx;
        prog_wdata = data;
        @(posedge clk); #1;
        prog_we    = 1'b0;
    endtask

    // One isolated read: accept in the first cycle, then count cycles until valid.
    task automatic do_read(input string name, input logic [31:0] a,
                           input logic [31:0] exp_d, input logic exp_e);
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus.proc_req = 1'b1;
        bus.addr_in  = a;
        @(negedge clk);
        check({name, " rdy"}, {31'd0, bus.mem_rdy}, 32'd1);
        @(posedge clk); #1;
        bus.proc_req = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({name, " latency"}, lat, 32'd2);
        check({name, " rdata"}, bus.rdata, exp_d);
        check({name, " err"}, {31'd0, bus.err}, {31'd0, exp_e});
        @(negedge clk);
        check({name, " pulse"}, {30'd0, bus.valid, bus.err}, 32'd0);
    endtask

    vec_t vecs[9];

    logic [31:0] s_addr [4];
    logic [31:0] s_data [4];

    initial begin
        vecs[0] = '{"rd0",      32'h0000_0000, W0,    1'b0};
        vecs[1] = '{"rd4",      32'h0000_0004, W1,    1'b0};
        vecs[2] = '{"rd8",      32'h0000_0008, W2,    1'b0};
        vecs[3] = '{"mis6",     32'h0000_0006, 32'h0, 1'b1};
        vecs[4] = '{"oor1000",  32'h0000_1000, 32'h0, 1'b1};
        vecs[5] = '{"top",      32'h0000_0FFC, WTOP,  1'b0};
        vecs[6] = '{"mis1",     32'h0000_0001, 32'h0, 1'b1};
        vecs[7] = '{"oorhigh",  32'hFFFF_FFFC, 32'h0, 1'b1};
        vecs[8] = '{"rdC",      32'h0000_000C, W3,    1'b0};
        s_addr  = '{32'h0, 32'h4, 32'h8, 32'hC};
        s_data  = '{W0, W1, W2, W3};

        rst          = 1'b0;
        stall_en     = 1'b0;
        prog_we      = 1'b0;
        prog_addr    = '0;
        prog_wdata   = '0;
        bus.proc_req = 1'b0;
        bus.addr_in  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst valid", {31'd0, bus.valid}, 32'd0);
        check("rst rdata", bus.rdata, 32'd0);
        check("rst err", {31'd0, bus.err}, 32'd0);
        check("rst rdy", {31'd0, bus.mem_rdy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        prog(10'd0, W0);
        prog(10'd1, W1);
        prog(10'd2, W2);
        prog(10'd3, W3);
        prog(10'd1023, WTOP);

        // Single read followed by a back-to-back request in the response cycle.
        @(posedge clk); #1;
        bus.proc_req = 1'b1;
        bus.addr_in  = 32'h0;
        @(negedge clk);
        check("b2b c0 rdy", {31'd0, bus.mem_rdy}, 32'd1);
        check("b2b c0 valid", {31'd0, bus.valid}, 32'd0);
        @(posedge clk); #1;
        bus.proc_req = 1'b0;
        @(negedge clk);
        check("b2b c1 valid", {31'd0, bus.valid}, 32'd0);
        check("b2b c1 rdy", {31'd0, bus.mem_rdy}, 32'd0);
        @(posedge clk); #1;
        bus.proc_req = 1'b1;
        bus.addr_in  = 32'h4;
        @(negedge clk);
        check("b2b c2 valid", {31'd0, bus.valid}, 32'd1);
        check("b2b c2 rdata", bus.rdata, W0);
        check("b2b c2 err", {31'd0, bus.err}, 32'd0);
        check("b2b c2 rdy", {31'd0, bus.mem_rdy}, 32'd1);
        @(posedge clk); #1;
        bus.proc_req = 1'b0;
        @(negedge clk);
        check("b2b c3 valid", {31'd0, bus.valid}, 32'd0);
        check("b2b c3 rdata hold", bus.rdata, W0);
        @(negedge clk);
        check("b2b c4 valid", {31'd0, bus.valid}, 32'd1);
        check("b2b c4 rdata", bus.rdata, W1);
        @(negedge clk);
        check("b2b c5 valid", {31'd0, bus.valid}, 32'd0);

        // Table-driven single reads, including misaligned and out-of-range addresses.
        for (int i = 0; i < 9; i++) begin
            do_read(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].err);
        end

        // Stall injection: requests held until accepted; rdy checked against the golden LFSR.
        begin
            mstate_t ms, ms_nx;
            int      req_idx, resp_idx;
            bit      exp_rdy, acc;
            ms       = M_IDLE;
            req_idx  = 0;
            resp_idx = 0;
            @(posedge clk); #1;
            stall_en     = 1'b1;
            bus.proc_req = 1'b1;
            bus.addr_in  = s_addr[0];
            for (int cyc = 0; cyc < 300 && resp_idx < 4; cyc++) begin
                @(negedge clk);
                exp_rdy = (ms != M_WAIT) && !lfsr_m[0];
                check("stall rdy", {31'd0, bus.mem_rdy}, {31'd0, exp_rdy});
                check("stall valid", {31'd0, bus.valid}, {31'd0, ms == M_RESP});
                if (ms == M_RESP) begin
                    check("stall rdata", bus.rdata, s_data[resp_idx]);
                    resp_idx++;
                end
                acc = bus.proc_req && exp_rdy;
                case (ms)
                    M_WAIT:  ms_nx = M_RESP;
                    default: ms_nx = acc ? M_WAIT : M_IDLE;
                endcase
                if (acc) req_idx++;
                @(posedge clk); #1;
                ms           = ms_nx;
                bus.proc_req = (req_idx < 4);
                if (req_idx < 4) bus.addr_in = s_addr[req_idx];
            end
            check("stall accepts", req_idx, 32'd4);
            check("stall responses", resp_idx, 32'd4);
            stall_en     = 1'b0;
            bus.proc_req = 1'b0;
            @(negedge clk);
            check("stall end valid", {31'd0, bus.valid}, 32'd0);
        end

        // Load write to word 1 on the same edge the read of word 1 enters RESP.
        @(posedge clk); #1;
        bus.proc_req = 1'b1;
        bus.addr_in  = 32'h4;
        @(negedge clk);
        check("coll rdy", {31'd0, bus.mem_rdy}, 32'd1);
        @(posedge clk); #1;
        bus.proc_req = 1'b0;
        prog_we      = 1'b1;
        prog_addr    = 10'd1;
        prog_wdata   = WNEW;
        @(negedge clk);
        check("coll wait valid", {31'd0, bus.valid}, 32'd0);
        @(posedge clk); #1;
        prog_we = 1'b0;
        @(negedge clk);
        check("coll valid", {31'd0, bus.valid}, 32'd1);
        check("coll old word", bus.rdata, W1);
        do_read("coll reread", 32'h4, WNEW, 1'b0);

        // Reset while a request sits in WAIT.
        @(posedge clk); #1;
        bus.proc_req = 1'b1;
        bus.addr_in  = 32'h0;
        @(posedge clk); #1;
        bus.proc_req = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        check("midrst valid", {31'd0, bus.valid}, 32'd0);
        check("midrst rdy", {31'd0, bus.mem_rdy}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst valid", {31'd0, bus.valid}, 32'd0);
            check("postrst rdy", {31'd0, bus.mem_rdy}, 32'd1);
        end
        do_read("postrst rd0", 32'h0, W0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
